// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI responder endpoint with synchronized SCK/CS/MOSI and a tx holding register
module spi_responder #(
  parameter int DataBits   = 16,
  parameter int Cpol       = 0,
  parameter int Cpha       = 0,
  parameter int SyncStages = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_clk_ni,
  input  logic                          sck_i,
  input  logic                          cs_i,
  input  logic                          mosi_i,
  output logic                          miso_o,
  output logic                          miso_oe_o,
  input  logic [DataBits-1:0]           tx_data_i,
  input  logic                          tx_load_i,
  output logic                          tx_ready_o,
  output logic [DataBits-1:0]           rx_data_o,
  output logic                          rx_valid_o,
  output logic                          frame_err_o,
  output logic                          underrun_o,
  output logic [$clog2(DataBits+1)-1:0] bit_cnt_o
);

  localparam int              CntW       = $clog2(DataBits + 1);
  localparam logic [CntW-1:0] CntFull    = CntW'(DataBits);
  localparam logic [CntW-1:0] CntLast    = CntW'(DataBits - 1);
  localparam logic            CpolBit    = (Cpol != 0);
  localparam logic            CphaBit    = (Cpha != 0);
  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling edge.
  localparam logic            SampleRise = (CpolBit == CphaBit);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_e;

  state_e                state;
  logic [SyncStages-1:0] sck_sync;
  logic [SyncStages-1:0] cs_sync;
  logic [SyncStages-1:0] mosi_sync;
  logic                  sck_q;
  logic                  sck_s;
  logic                  cs_s;
  logic                  mosi_s;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  sample_edge;
  logic                  shift_edge;
  logic [DataBits:0]     tx_sr;
  logic [DataBits-1:0]   rx_sr;
  logic [DataBits-1:0]   hold_q;
  logic                  hold_full;
  logic                  overflow;
  logic                  load_fire;
  logic [CntW-1:0]       bit_cnt;

  assign sck_s       = sck_sync[SyncStages-1];
  assign cs_s        = cs_sync[SyncStages-1];
  assign mosi_s      = mosi_sync[SyncStages-1];
  assign sck_rise    = sck_s & ~sck_q;
  assign sck_fall    = ~sck_s & sck_q;
  assign sample_edge = SampleRise ? sck_rise : sck_fall;
  assign shift_edge  = SampleRise ? sck_fall : sck_rise;
  assign load_fire   = tx_load_i & ~hold_full;

  // The extra top bit of tx_sr delays MSB by one shift edge for Cpha=1.
  assign miso_o     = CphaBit ? tx_sr[DataBits] : tx_sr[DataBits-1];
  assign tx_ready_o = ~hold_full;
  assign bit_cnt_o  = bit_cnt;

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state       <= WAIT_IDLE;
      sck_sync    <= {SyncStages{CpolBit}};
      cs_sync     <= '0;
      mosi_sync   <= '0;
      sck_q       <= CpolBit;
      tx_sr       <= '0;
      rx_sr       <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      overflow    <= 1'b0;
      bit_cnt     <= '0;
      miso_oe_o   <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      sck_sync    <= {sck_sync[SyncStages-2:0], sck_i};
      cs_sync     <= {cs_sync[SyncStages-2:0], cs_i};
      mosi_sync   <= {mosi_sync[SyncStages-2:0], mosi_i};
      sck_q       <= sck_s;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      underrun_o  <= 1'b0;

      if (load_fire) begin
        hold_q    <= tx_data_i;
        hold_full <= 1'b1;
      end

      case (state)
        WAIT_IDLE: begin
          if (cs_s) state <= IDLE;
        end

        IDLE: begin
          if (!cs_s) begin
            state      <= ACTIVE;
            miso_oe_o  <= 1'b1;
            bit_cnt    <= '0;
            overflow   <= 1'b0;
            rx_sr      <= '0;
            tx_sr      <= hold_full ? {1'b0, hold_q} : '0;
            underrun_o <= ~hold_full;
            // A load can only fire into an empty register, so it becomes the next frame's word.
            hold_full  <= load_fire;
          end
        end

        ACTIVE: begin
          if (cs_s) begin
            state       <= IDLE;
            miso_oe_o   <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            frame_err_o <= (bit_cnt != CntFull) | overflow;
          end else begin
            if (shift_edge) tx_sr <= {tx_sr[DataBits-1:0], 1'b0};
            if (sample_edge) begin
              if (bit_cnt == CntFull) begin
                overflow <= 1'b1;
              end else begin
                rx_sr   <= {rx_sr[DataBits-2:0], mosi_s};
                bit_cnt <= bit_cnt + CntW'(1);
                if (bit_cnt == CntLast) begin
                  rx_data_o  <= {rx_sr[DataBits-2:0], mosi_s};
                  rx_valid_o <= 1'b1;
                end
              end
            end
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
